// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with push/pop strobes, top-of-stack peek and occupancy count.
// Define LIFO_STACK_ERR_EN to build sticky overflow/underflow flags cleared by err_clr.
module lifo_stack #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = DEPTH - 2,
  parameter int CW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;

  assign top_idx     = AW'(count - CW'(1));
  assign wr_idx      = AW'(count);
  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AFULL_LEVEL));
  assign top         = empty ? '0 : mem[top_idx];

  // Storage carries no reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && pop && !empty) begin
      mem[top_idx] <= data_in;
    end else if (push && !pop && !full) begin
      mem[wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (pop) begin
        if (!empty) begin
          data_out  <= mem[top_idx];
          valid_out <= 1'b1;
          if (!push) begin
            count <= count - CW'(1);
          end
        end else if (push) begin
          // Empty bypass: the pushed word goes straight out, stack stays empty.
          data_out  <= data_in;
          valid_out <= 1'b1;
        end
      end else if (push && !full) begin
        count <= count + CW'(1);
      end
    end
  end

`ifdef LIFO_STACK_ERR_EN
  logic ovf_event;
  logic unf_event;

  assign ovf_event = push && !pop && full;
  assign unf_event = pop && !push && empty;

  // A same-cycle error event overrides err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (unf_event) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`else
  logic err_clr_unused;

  assign err_clr_unused = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Table-driven bench for lifo_stack (WIDTH=4, DEPTH=8, AFULL_LEVEL=6) with a pop-data scoreboard.
module tb_lifo_stack;

`ifdef LIFO_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push;
  logic       pop;
  logic [3:0] data_in;
  logic       err_clr;
  logic [3:0] data_out;
  logic       valid_out;
  logic [3:0] top;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       push;
    bit       pop;
    bit [3:0] din;
    bit       clr;
    bit [3:0] e_top;
    int       e_count;
    bit       e_vout;
    bit [3:0] e_dout;
    bit       e_ovf;
    bit       e_unf;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] model[$];
  logic [3:0] sb_q[$];

  lifo_stack #(.WIDTH(4), .DEPTH(8), .AFULL_LEVEL(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .pop         (pop),
    .data_in     (data_in),
    .err_clr     (err_clr),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .top         (top),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(bit ps, bit pp, bit [3:0] din, bit clr, bit [3:0] tp,
                             int cnt, bit vo, bit [3:0] dout, bit ovf, bit unf);
    vec_t r;
    r.push = ps; r.pop = pp; r.din = din; r.clr = clr; r.e_top = tp;
    r.e_count = cnt; r.e_vout = vo; r.e_dout = dout; r.e_ovf = ovf; r.e_unf = unf;
    return r;
  endfunction

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    push = t.push; pop = t.pop; data_in = t.din; err_clr = t.clr;
    // reference stack: expected pop data goes to the scoreboard
    if (t.push && t.pop) begin
      if (model.size() > 0) begin
        sb_q.push_back(model[$]);
        model[$] = t.din;
      end else begin
        sb_q.push_back(t.din);
      end
    end else if (t.pop) begin
      if (model.size() > 0) sb_q.push_back(model.pop_back());
    end else if (t.push) begin
      if (model.size() < 8) model.push_back(t.din);
    end
    @(posedge clk);
    #1;
    chk({tag, ".count"},       count,       t.e_count);
    chk({tag, ".top"},         top,         t.e_top);
    chk({tag, ".valid_out"},   valid_out,   t.e_vout);
    chk({tag, ".data_out"},    data_out,    t.e_dout);
    chk({tag, ".full"},        full,        (t.e_count == 8));
    chk({tag, ".empty"},       empty,       (t.e_count == 0));
    chk({tag, ".almost_full"}, almost_full, (t.e_count >= 6));
    chk({tag, ".overflow"},    overflow,    t.e_ovf & ERR_EN);
    chk({tag, ".underflow"},   underflow,   t.e_unf & ERR_EN);
    if (valid_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk({tag, ".sb_expected"}, 32'd0, 32'd1);
      end else begin
        chk({tag, ".sb_data"}, data_out, sb_q.pop_front());
      end
    end
    chk({tag, ".model_count"}, count, model.size());
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.count", count, 0);
    chk("reset.empty", empty, 1);
    chk("reset.top", top, 0);
    chk("reset.data_out", data_out, 0);
    chk("reset.flags", {overflow, underflow, full, almost_full, valid_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-fill, asserted asynchronously while valid_out is high
    apply(v(1, 0, 4'h3, 0, 4'h3, 1, 0, 4'h0, 0, 0), "rm0");
    apply(v(1, 0, 4'h5, 0, 4'h5, 2, 0, 4'h0, 0, 0), "rm1");
    apply(v(1, 0, 4'h9, 0, 4'h9, 3, 0, 4'h0, 0, 0), "rm2");
    apply(v(0, 1, 4'h0, 0, 4'h5, 2, 1, 4'h9, 0, 0), "rm3");
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst.count", count, 0);
    chk("async_rst.empty", empty, 1);
    chk("async_rst.top", top, 0);
    chk("async_rst.data_out", data_out, 0);
    chk("async_rst.valid_out", valid_out, 0);
    model.delete();
    sb_q.delete();
    push = 1'b0; pop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 1; i <= 8; i++)
      vecs.push_back(v(1, 0, 4'(i), 0, 4'(i), i, 0, 4'h0, 0, 0));
    vecs.push_back(v(1, 0, 4'hA, 0, 4'h8, 8, 0, 4'h0, 1, 0));   // push when full
    vecs.push_back(v(1, 1, 4'hF, 0, 4'hF, 8, 1, 4'h8, 1, 0));   // replace top when full
    vecs.push_back(v(0, 1, 4'h0, 0, 4'h7, 7, 1, 4'hF, 1, 0));
    for (int i = 7; i >= 1; i--)
      vecs.push_back(v(0, 1, 4'h0, 0, 4'(i - 1), i - 1, 1, 4'(i), 1, 0));
    vecs.push_back(v(0, 1, 4'h0, 0, 4'h0, 0, 0, 4'h1, 1, 1));   // pop when empty
    vecs.push_back(v(0, 0, 4'h0, 1, 4'h0, 0, 0, 4'h1, 0, 0));   // err_clr
    vecs.push_back(v(1, 0, 4'h2, 0, 4'h2, 1, 0, 4'h1, 0, 0));
    vecs.push_back(v(1, 0, 4'h4, 0, 4'h4, 2, 0, 4'h1, 0, 0));
    vecs.push_back(v(1, 1, 4'hF, 0, 4'hF, 2, 1, 4'h4, 0, 0));   // replace top
    vecs.push_back(v(0, 1, 4'h0, 0, 4'h2, 1, 1, 4'hF, 0, 0));
    vecs.push_back(v(0, 1, 4'h0, 0, 4'h0, 0, 1, 4'h2, 0, 0));
    vecs.push_back(v(1, 1, 4'hC, 0, 4'h0, 0, 1, 4'hC, 0, 0));   // empty bypass
    vecs.push_back(v(0, 1, 4'h0, 1, 4'h0, 0, 0, 4'hC, 0, 1));   // error beats err_clr
    vecs.push_back(v(0, 0, 4'h0, 0, 4'h0, 0, 0, 4'hC, 0, 1));   // sticky
    vecs.push_back(v(0, 0, 4'h0, 1, 4'h0, 0, 0, 4'hC, 0, 0));
    vecs.push_back(v(1, 0, 4'h6, 0, 4'h6, 1, 0, 4'hC, 0, 0));
    vecs.push_back(v(0, 0, 4'h0, 0, 4'h6, 1, 0, 4'hC, 0, 0));   // idle holds

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    @(negedge clk);
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised synchronous LIFO (stack) buffer with independent push and pop strobes, a combinational top-of-stack peek and an occupancy count. Simultaneous push and pop replace the top entry in a single cycle. Sticky overflow/underflow error flags can be compiled in. It is the general-purpose stack for datapaths needing last-in-first-out buffering of WIDTH-bit words, replacing the fixed 4-bit × 8 single-`rw` stack.

## Interface
Parameters:
- WIDTH, 4, data word width in bits (≥1)
- DEPTH, 8, number of entries (≥2)
- AFULL_LEVEL, DEPTH-2, `almost_full` asserts when `count` ≥ this value (1..DEPTH)
- CW, $clog2(DEPTH+1), derived width of `count`; not overridden

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  reset, asynchronous and active-low
- push  input  1  write `data_in` onto the stack this cycle
- pop  input  1  read the top entry into `data_out` this cycle
- data_in  input  WIDTH  word to push
- err_clr  input  1  synchronous clear of `overflow`/`underflow`
- data_out  output  WIDTH  registered popped word; holds between pops
- valid_out  output  1  one-cycle pulse: `data_out` was loaded at the last edge
- top  output  WIDTH  combinational peek of the top entry; 0 when empty
- count  output  CW  current occupancy, 0..DEPTH
- full  output  1  `count` == DEPTH
- empty  output  1  `count` == 0
- almost_full  output  1  `count` ≥ AFULL_LEVEL
- overflow  output  1  sticky: push rejected because the stack was full
- underflow  output  1  sticky: pop rejected because the stack was empty

## Operation
- Storage: `mem[0..DEPTH-1]`; `count` is the sole pointer. The top entry is `mem[count-1]`. `full`, `empty` and `almost_full` decode from the registered `count`, so there is no separate flag lag.
- Per rising edge, with `count` = n:
  - push only, n<DEPTH: `mem[n]`←`data_in`; `count`←n+1.
  - push only, n==DEPTH: ignored; memory and `count` unchanged; `overflow`←1.
  - pop only, n>0: `data_out`←`mem[n-1]`; `valid_out`←1; `count`←n-1.
  - pop only, n==0: ignored; `data_out` holds; `valid_out`←0; `underflow`←1.
  - push+pop, n>0 (including full): `data_out`←`mem[n-1]`; `mem[n-1]`←`data_in`; `count` unchanged; `valid_out`←1; no error.
  - push+pop, n==0: bypass. `data_out`←`data_in`; `valid_out`←1; `count` stays 0; no error.
  - neither: `valid_out`←0; all else holds.
- `top` = `mem[count-1]` when `count`>0, else 0. Memory contents are never exposed as X.
- `err_clr` clears both error flags at the edge. An error event in the same cycle wins, so that flag reads 1 afterward.
- Reset (`rst_n` low, any time, including mid-operation): `count`=0, `data_out`=0, `valid_out`=0, `overflow`=0, `underflow`=0, so `empty`=1, `full`=0, `almost_full`=0 (for AFULL_LEVEL≥1), `top`=0. Memory is not cleared. Reset release is synchronised by the integrator. The first edge with `rst_n` high operates normally.

## Timing
- Pop latency: 1 cycle. `data_out` and `valid_out` are valid after the edge that samples `pop`.
- Push visibility: `top` and `count` reflect the push immediately after the sampling edge.
- Flags are combinational from `count` and change only after a clock edge or on reset assertion.
- No back-pressure handshake. Callers gate `push` with `full` and `pop` with `empty`. Violations are absorbed as described above.

## Configuration
- LIFO_STACK_ERR_EN defined: `overflow`/`underflow` are sticky registers with `err_clr` as specified.
- LIFO_STACK_ERR_EN undefined: both outputs are tied to 0, `err_clr` is ignored, and no error registers are built. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=4, DEPTH=8, AFULL_LEVEL=6.
- Reset mid-fill: push 0x3,0x5,0x9, then assert `rst_n`=0 asynchronously → `count`=0, `empty`=1, `top`=0, `data_out`=0, `valid_out`=0 without waiting for a clock edge.
- Fill and drain: push 0x1..0x8 → `almost_full` rises at `count`=6, `full` at 8. Then pop 8 times → `data_out` = 0x8,0x7,…,0x1, each with a `valid_out` pulse; `empty`=1 at the end.
- Overflow/underflow (macro on): push 0xA when full → `count` stays 8, `top` stays 0x8, `overflow`=1. Drain, then pop when empty → `underflow`=1, `data_out` unchanged. Assert `err_clr` → both flags 0. Repeat with the macro off → both flags stay 0.
- Replace-top: with 0x2,0x4 stacked, push 0xF with pop → `data_out`=0x4, `top`=0xF, `count`=2. Repeat when full → `count` stays 8, no `overflow`.
- Empty bypass: `count`=0, push 0xC with pop → `data_out`=0xC, `valid_out`=1, `count`=0, `empty`=1, no `underflow`.
- Error priority: pop when empty with `err_clr`=1 in the same cycle → `underflow`=1 afterward.
